// File: rtl/rx_packet_ctrl.sv
// USB-style RX packet controller. It drains the bytes that follow the PID from
// the rx FIFO, runs CRC5/CRC16 over them and streams the data payload out.
// When the packet ends it classifies the PID and reports status for one cycle.
module rx_packet_ctrl #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       r_error,
  input  logic [3:0] PID,
  input  logic       empty,
  input  logic [7:0] r_data,
  output logic       r_enable,
  output logic [7:0] pd_data,
  output logic       pd_valid,
  output logic       pkt_done,
  output logic [1:0] pkt_type,
  output logic [3:0] pkt_pid,
  output logic       crc_ok,
  output logic       pkt_err,
  output logic [6:0] byte_cnt,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  localparam logic [6:0] MAXP = 7'(MAX_PAYLOAD);

  state_t      r_state, w_next;
  logic [15:0] r_crc16;
  logic [4:0]  r_crc5;
  logic [6:0]  r_raw, r_emit;
  logic [7:0]  r_dly0, r_dly1;
  logic        r_err_stk, r_ovf;
  logic [3:0]  r_pid;
  logic [6:0]  r_taddr;
  logic [3:0]  r_tendp;

  logic        w_pop, w_start, w_finish, w_is_data, w_pay, w_emit, w_over;
  logic [1:0]  w_type;
  logic        w_len_ok, w_crc_ok, w_err;

  // LSB-first CRC16 (x^16+x^15+x^2+1), one whole byte per call
  function automatic logic [15:0] f_crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    logic        fb;
    x = c;
    for (int i = 0; i < 8; i++) begin
      fb = x[15] ^ d[i];
      x  = {x[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return x;
  endfunction

  // LSB-first CRC5 (x^5+x^2+1), one whole byte per call
  function automatic logic [4:0] f_crc5(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] x;
    logic       fb;
    x = c;
    for (int i = 0; i < 8; i++) begin
      fb = x[4] ^ d[i];
      x  = {x[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return x;
  endfunction

  assign w_pop     = r_enable;
  assign w_start   = (r_state == IDLE) && rcving;
  assign w_finish  = (r_state == RECV) && (w_next == CHECK);
  assign w_is_data = (r_pid == 4'b0011) || (r_pid == 4'b1011);
  // The first two pops only prime the delay line, so the trailing CRC never leaves
  assign w_pay     = w_pop && (r_raw >= 7'd2) && w_is_data;
  assign w_emit    = w_pay && (r_emit < MAXP);
  assign w_over    = w_pay && !(r_emit < MAXP);

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and FIFO pop
  always_comb begin
    w_next   = r_state;
    r_enable = 1'b0;
    case (r_state)
      IDLE:    if (rcving) w_next = RECV;
      RECV: begin
        r_enable = !empty;
        if (!rcving && empty) w_next = CHECK;
      end
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // PID classification and error roll-up, sampled as the packet closes
  always_comb begin
    w_type   = 2'b11;
    w_len_ok = 1'b1;
    w_crc_ok = 1'b0;
    case (r_pid)
      4'b0001, 4'b1001, 4'b1101: begin
        w_type   = 2'b00;
        w_len_ok = (r_raw == 7'd2);
        w_crc_ok = (r_crc5 == 5'h0C);
      end
      4'b0011, 4'b1011: begin
        w_type   = 2'b01;
        w_len_ok = (r_raw >= 7'd2);
        w_crc_ok = (r_crc16 == 16'h800D);
      end
      4'b0010, 4'b1010, 4'b1110: begin
        w_type   = 2'b10;
        w_len_ok = (r_raw == 7'd0);
        w_crc_ok = 1'b1;
      end
      default: ;
    endcase
    w_err = r_err_stk | r_error | !w_len_ok | r_ovf | !w_crc_ok | (w_type == 2'b11);
  end

  // Datapath: per-packet accumulation, payload stream and status capture
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_crc16   <= 16'hFFFF;
      r_crc5    <= 5'h1F;
      r_raw     <= '0;
      r_emit    <= '0;
      r_dly0    <= '0;
      r_dly1    <= '0;
      r_err_stk <= 1'b0;
      r_ovf     <= 1'b0;
      r_pid     <= '0;
      r_taddr   <= '0;
      r_tendp   <= '0;
      pd_data   <= '0;
      pd_valid  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_type  <= '0;
      pkt_pid   <= '0;
      crc_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      byte_cnt  <= '0;
      tok_addr  <= '0;
      tok_endp  <= '0;
    end else begin
      pd_valid <= w_emit;
      pkt_done <= w_finish;
      if (w_emit) begin
        pd_data <= r_dly1;
        r_emit  <= r_emit + 7'd1;
      end
      if (w_over) r_ovf <= 1'b1;
      if (w_start) begin
        r_crc16   <= 16'hFFFF;
        r_crc5    <= 5'h1F;
        r_raw     <= '0;
        r_emit    <= '0;
        r_dly0    <= '0;
        r_dly1    <= '0;
        r_err_stk <= 1'b0;
        r_ovf     <= 1'b0;
        r_pid     <= PID;
      end
      if (w_pop) begin
        r_crc16 <= f_crc16(r_crc16, r_data);
        // CRC5 only covers the two token bytes
        if (r_raw < 7'd2) r_crc5 <= f_crc5(r_crc5, r_data);
        if (r_raw != 7'd127) r_raw <= r_raw + 7'd1;
        r_dly0 <= r_data;
        r_dly1 <= r_dly0;
        if (r_raw == 7'd0) begin
          r_taddr    <= r_data[6:0];
          r_tendp[0] <= r_data[7];
        end
        if (r_raw == 7'd1) r_tendp[3:1] <= r_data[2:0];
      end
      if ((r_state == RECV) && r_error) r_err_stk <= 1'b1;
      if (w_finish) begin
        pkt_type <= w_type;
        pkt_pid  <= r_pid;
        crc_ok   <= w_crc_ok;
        pkt_err  <= w_err;
        byte_cnt <= r_emit;
        tok_addr <= r_taddr;
        tok_endp <= r_tendp;
      end
    end
  end

endmodule

// File: doc/rx_packet_ctrl.md
RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 Parameter: MAX_PAYLOAD, 64, maximum data-packet payload bytes accepted.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 rcving  input  1  receiver busy with a packet.
REQ-005 r_error  input  1  receiver error flag.
REQ-006 PID  input  4  decoded packet PID; stable while rcving=1 and until the next packet.
REQ-007 empty  input  1  rx FIFO empty.
REQ-008 r_data  input  8  rx FIFO head byte; valid combinationally while empty=0.
REQ-009 r_enable  output  1  FIFO pop; head is removed at the edge where r_enable=1.
REQ-010 pd_data  output  8  payload byte out.
REQ-011 pd_valid  output  1  one-cycle strobe qualifying pd_data; no backpressure.
REQ-012 pkt_done  output  1  one-cycle strobe; status outputs below are valid in that cycle and held until the next pkt_done.
REQ-013 pkt_type  output  2  00 token, 01 data, 10 handshake, 11 invalid.
REQ-014 pkt_pid  output  4  PID captured for the packet.
REQ-015 crc_ok  output  1  CRC residual check passed (1 for handshake).
REQ-016 pkt_err  output  1  any packet error.
REQ-017 byte_cnt  output  7  payload bytes emitted.
REQ-018 tok_addr / tok_endp  output  7 / 4  token address and endpoint.

Function
REQ-019 The FIFO holds only the bytes following the PID byte; the PID byte is never popped by this block.
REQ-020 FSM states: IDLE, RECV, CHECK. IDLE->RECV when rcving=1 (level). RECV->CHECK when rcving=0 and empty=1. CHECK->IDLE unconditionally after one cycle.
REQ-021 r_enable = 1 exactly when state=RECV and empty=0; one byte is popped per cycle.
REQ-022 Every popped byte increments a raw counter (saturates at 127) and updates CRC5 and CRC16 in parallel, LSB-first, one full byte per cycle.
REQ-023 CRC16: poly x^16+x^15+x^2+1, init 0xFFFF on IDLE->RECV, pass condition residual == 0x800D after all bytes.
REQ-024 CRC5: poly x^5+x^2+1, init 0x1F, computed over the 16 token bits, pass condition residual == 0x0C.
REQ-025 Token layout: byte0[6:0]=addr, byte0[7]=endp[0], byte1[2:0]=endp[3:1], byte1[7:3]=CRC5; tok_addr/tok_endp are latched from bytes 0-1 in every packet, and are meaningful only for tokens.
REQ-026 Payload pipeline: a 2-byte delay line; when the 3rd and later bytes are popped, and PID is DATA0 (0011) or DATA1 (1011), the byte popped two pops earlier appears on pd_data with pd_valid=1 in the following cycle; the final two bytes (CRC) are never emitted.
REQ-027 After MAX_PAYLOAD payload bytes have been emitted, further bytes are popped and CRC'd but not emitted; overflow is flagged.
REQ-028 r_error=1 in any cycle of RECV sets a sticky error flag for the packet.
REQ-029 In CHECK, classify PID: OUT 0001 / IN 1001 / SETUP 1101 -> token (raw count must be 2, crc_ok = CRC5 pass); DATA0/DATA1 -> data (raw count >= 2, crc_ok = CRC16 pass); ACK 0010 / NAK 1010 / STALL 1110 -> handshake (raw count must be 0, crc_ok=1); all other PIDs -> invalid (crc_ok=0).
REQ-030 pkt_err = sticky r_error | length mismatch | overflow | !crc_ok | invalid type.
REQ-031 pkt_done pulses in the CHECK cycle, with status registered in that same cycle.
REQ-032 If rcving is reasserted during CHECK, IDLE enters RECV on the next cycle; bytes remain buffered in the FIFO and are not lost.
REQ-033 In CHECK, pd_valid=0.

Reset
REQ-034 On a clock edge with n_rst=0: state=IDLE and all outputs, counters, delay line, sticky flags =0; CRC registers =init values.
REQ-035 Reset applied mid-RECV abandons the packet: no pkt_done and no further pd_valid.

Verification
REQ-036 ACK (PID 0010), no bytes -> one pkt_done, pkt_type=10, crc_ok=1, pkt_err=0, byte_cnt=0, r_enable never high.
REQ-037 DATA0, bytes 00 00 (zero-length payload, valid CRC16) -> pkt_type=01, crc_ok=1, byte_cnt=0, no pd_valid.
REQ-038 DATA1, payload 00 01 02 03 plus bench-computed CRC16 -> pd_valid x4 with data 00,01,02,03 in order, byte_cnt=4, pkt_err=0; a corrupted CRC byte gives crc_ok=0 and pkt_err=1.
REQ-039 SETUP token addr=0x15 endp=0xE with bench-computed CRC5 -> tok_addr=0x15, tok_endp=0xE, crc_ok=1; 3 bytes sent -> pkt_err=1.
REQ-040 DATA0 with 66 payload bytes -> exactly 64 pd_valid, pkt_err=1; r_error pulsed mid-packet -> pkt_err=1.
REQ-041 n_rst=0 during RECV after 3 bytes -> all outputs 0 next cycle, state IDLE, next packet is processed normally.
